// File: rtl/edgetracing_mul_arbiter.sv
// edgetracing_mul_arbiter
// Round-robin front end for one shared, externally instantiated pipelined
// multiplier (signed A x unsigned B). Each cycle at most one requester is
// granted and its operands are presented on mul_din0/mul_din1. A small
// tracker (valid + requester ID per stage) runs in lock-step with the
// multiplier registers so the product leaving mul_dout can be steered back
// to its owner. The whole pipeline, bubbles included, freezes through
// mul_ce while the head result waits for its owner's res_ready.
//
// Combinational paths that integrators must account for:
//   res_ready -> mul_ce -> req_ready
//   req_valid -> req_ready
module edgetracing_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int A_WIDTH     = 12,
  parameter int B_WIDTH     = 6,
  parameter int P_WIDTH     = 18,
  parameter int MUL_LATENCY = 3,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int CNT_W       = $clog2(MUL_LATENCY + 1)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]         res_valid,
  input  logic [NUM_REQ-1:0]         res_ready,
  output logic [P_WIDTH-1:0]         res_p,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic [CNT_W-1:0]           inflight
);

  // Number of set bits in the tracker valid vector.
  function automatic logic [CNT_W-1:0] popcount_vld(input logic [MUL_LATENCY-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int s = 0; s < MUL_LATENCY; s++) begin
      cnt = cnt + CNT_W'(v[s]);
    end
    return cnt;
  endfunction

  // Tracker state: one valid bit and one owner ID per multiplier stage.
  logic [MUL_LATENCY-1:0] vld_q, vld_d;
  logic [ID_W-1:0]        id_q [MUL_LATENCY];
  logic [ID_W-1:0]        id_d [MUL_LATENCY];

  // Most recently granted requester; search starts one past it.
  logic [ID_W-1:0]        last_q, last_d;

  // Arbiter and stall decode.
  logic [NUM_REQ-1:0]     grant_s;
  logic [ID_W-1:0]        grant_id_s;
  logic                   grant_any_s;
  logic                   head_vld_s;
  logic [ID_W-1:0]        head_id_s;
  logic                   ce_s;
  logic                   issue_s;

  // Head-of-pipeline stall: only an unaccepted head result freezes the pipe.
  always_comb begin
    head_vld_s = vld_q[MUL_LATENCY-1];
    head_id_s  = id_q[MUL_LATENCY-1];
    ce_s       = !head_vld_s || res_ready[head_id_s];
  end

  // Round-robin grant: first requesting index after last_q, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W-1:0] sel;
    logic            hit;
    grant_s     = '0;
    grant_id_s  = '0;
    grant_any_s = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel          = ID_W'((int'(last_q) + k) % NUM_REQ);
      hit          = !grant_any_s && req_valid[sel];
      grant_s[sel] = grant_s[sel] | hit;
      grant_id_s   = hit ? sel : grant_id_s;
      grant_any_s  = grant_any_s | hit;
    end
  end

  // Accept handshake: a grant only turns into an issue while the pipe advances.
  always_comb begin
    req_ready = {NUM_REQ{ce_s}} & grant_s;
    issue_s   = ce_s && grant_any_s;
  end

  // Operand mux: AND-OR of the granted slice, all-zero when nobody is granted.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mul_din0 = mul_din0 | ({A_WIDTH{grant_s[i]}} & req_a[i*A_WIDTH +: A_WIDTH]);
      mul_din1 = mul_din1 | ({B_WIDTH{grant_s[i]}} & req_b[i*B_WIDTH +: B_WIDTH]);
    end
  end

  // Result steering: one-hot valid toward the head owner, product passed through.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      res_valid[i] = head_vld_s && (head_id_s == ID_W'(i));
    end
    res_p    = mul_dout;
    mul_ce   = ce_s;
    inflight = popcount_vld(vld_q);
  end

  // Tracker and pointer next state: shift in lock-step with the multiplier.
  always_comb begin
    vld_d  = vld_q;
    id_d   = id_q;
    last_d = last_q;
    if (ce_s) begin
      for (int s = MUL_LATENCY - 1; s > 0; s--) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
      end
      vld_d[0] = issue_s;
      id_d[0]  = grant_id_s;
    end else begin
      vld_d = vld_q;
      id_d  = id_q;
    end
    if (issue_s) begin
      last_d = grant_id_s;
    end else begin
      last_d = last_q;
    end
  end

  // State registers; reset discards in-flight work and gives requester 0 first priority.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= '0;
      last_q <= ID_W'(NUM_REQ - 1);
      for (int s = 0; s < MUL_LATENCY; s++) begin
        id_q[s] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        id_q[s] <= id_d[s];
      end
    end
  end

endmodule

// File: tb/tb_edgetracing_mul_arbiter.sv
// Bench for edgetracing_mul_arbiter: models the external 3-stage ce-gated
// multiplier and keeps a queue of expected (owner, product) results filled
// at each accepted issue and drained at each accepted result.
module tb_edgetracing_mul_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_a;
  logic [23:0] req_b;
  logic [3:0]  res_valid;
  logic [3:0]  res_ready;
  logic [17:0] res_p;
  logic        mul_ce;
  logic [11:0] mul_din0;
  logic [5:0]  mul_din1;
  logic [17:0] mul_dout;
  logic [1:0]  inflight;

  logic [11:0] tb_a [4];
  logic [5:0]  tb_b [4];

  typedef struct {
    logic [1:0]  id;
    logic [17:0] p;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  assign req_a = {tb_a[3], tb_a[2], tb_a[1], tb_a[0]};
  assign req_b = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};

  edgetracing_mul_arbiter dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .inflight  (inflight)
  );

  // External multiplier model: three ce-gated levels, no reset.
  logic [11:0]        m_a;
  logic [5:0]         m_b;
  logic [17:0]        m_p;
  logic [17:0]        m_out;
  logic signed [17:0] m_ea;
  logic signed [17:0] m_eb;
  assign m_ea     = 18'($signed(m_a));
  assign m_eb     = 18'({1'b0, m_b});
  assign mul_dout = m_out;

  always @(posedge ap_clk) begin
    if (mul_ce) begin
      m_a   <= mul_din0;
      m_b   <= mul_din1;
      m_p   <= m_ea * m_eb;
      m_out <= m_p;
    end
  end

  function automatic logic [17:0] exp_prod(input logic [11:0] a, input logic [5:0] b);
    int sa;
    int ub;
    int p;
    sa = int'($signed(a));
    ub = int'(b);
    p  = sa * ub;
    return p[17:0];
  endfunction

  // One clock: sample handshakes on the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t       e;
    logic [3:0] exp_v;
    @(negedge ap_clk);
    if (ap_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = 2'(i);
          e.p  = exp_prod(tb_a[i], tb_b[i]);
          sb.push_back(e);
        end
      end
      if ((res_valid & res_ready) != 4'b0000) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stale_result: res_valid=%b res_p=%h with nothing outstanding", res_valid, res_p);
        end else begin
          e     = sb.pop_front();
          exp_v = 4'b0001 << e.id;
          if (res_valid !== exp_v || res_p !== e.p) begin
            errors++;
            $display("FAIL result_order: got valid=%b p=%h, expected valid=%b p=%h", res_valid, res_p, exp_v, e.p);
          end
        end
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n  = 1'b0;
    req_valid = 4'b0000;
    res_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tb_a[i] = 12'h000;
      tb_b[i] = 6'd0;
    end
    sb.delete();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (inflight !== 2'd0)     begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
    checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL reset_res_valid: got %b expected 0000", res_valid); end
    checks++; if (mul_ce !== 1'b1)       begin errors++; $display("FAIL reset_mul_ce: got %b expected 1", mul_ce); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    cycle();
  endtask

  task automatic test_single();
    logic [1:0] exp_inf [4];
    exp_inf[0] = 2'd1; exp_inf[1] = 2'd1; exp_inf[2] = 2'd1; exp_inf[3] = 2'd0;
    tb_a[2]   = 12'hFFB;
    tb_b[2]   = 6'd7;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready: got %b expected 0100", req_ready); end
    checks++; if (mul_din0 !== 12'hFFB || mul_din1 !== 6'd7) begin errors++; $display("FAIL single_din: got %h/%h expected ffb/07", mul_din0, mul_din1); end
    cycle();
    req_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (inflight !== exp_inf[k]) begin errors++; $display("FAIL single_inflight[%0d]: got %0d expected %0d", k, inflight, exp_inf[k]); end
      checks++; if (res_valid !== ((k == 2) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_res_valid[%0d]: got %b", k, res_valid); end
      if (k == 2) begin
        checks++; if (res_p !== 18'h3FFDD) begin errors++; $display("FAIL single_res_p: got %h expected 3ffdd", res_p); end
      end
      cycle();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tb_a[i] = 12'(i * 301 - 700);
      tb_b[i] = 6'(i * 9 + 5);
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      if (c == 8) req_valid = 4'b0000;
      #1;
      if (c < 8) begin
        checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, 4'(1 << (c % 4))); end
      end
      if (c >= 3) begin
        checks++; if (res_valid !== 4'(1 << ((c - 3) % 4))) begin errors++; $display("FAIL rr_result[%0d]: got %b expected %b", c, res_valid, 4'(1 << ((c - 3) % 4))); end
      end
      cycle();
    end
  endtask

  task automatic test_back_pressure();
    logic [17:0] held;
    tb_a[1] = 12'h123; tb_b[1] = 6'd45;
    tb_a[2] = 12'hC01; tb_b[2] = 6'd17;
    tb_a[3] = 12'h7A5; tb_b[3] = 6'd62;
    held      = exp_prod(tb_a[1], tb_b[1]);
    res_ready = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'(1 << (k + 1));
      #1;
      checks++; if (req_ready !== req_valid) begin errors++; $display("FAIL bp_issue[%0d]: got %b expected %b", k, req_ready, req_valid); end
      cycle();
    end
    req_valid = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++; if (mul_ce !== 1'b0)       begin errors++; $display("FAIL bp_mul_ce[%0d]: got %b expected 0", s, mul_ce); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0000", s, req_ready); end
      checks++; if (res_valid !== 4'b0010 || res_p !== held) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 0010/%h", s, res_valid, res_p, held); end
      checks++; if (inflight !== 2'd3)     begin errors++; $display("FAIL bp_inflight[%0d]: got %0d expected 3", s, inflight); end
      cycle();
    end
    res_ready = 4'b1111;
    req_valid = 4'b0000;
    repeat (4) cycle();
    checks++; if (sb.size() != 0 || inflight !== 2'd0) begin errors++; $display("FAIL bp_drain: outstanding=%0d inflight=%0d expected 0/0", sb.size(), inflight); end
  endtask

  task automatic test_extremes();
    int hits;
    hits = 0;
    tb_a[0] = 12'h800; tb_b[0] = 6'd63;
    tb_a[1] = 12'h7FF; tb_b[1] = 6'd63;
    tb_a[2] = 12'h000; tb_b[2] = 6'd0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'(1 << k);
      cycle();
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (res_valid == 4'b0001) begin
        hits++;
        checks++; if (res_p !== 18'h20800) begin errors++; $display("FAIL ext_min: got %h expected 20800", res_p); end
      end else if (res_valid == 4'b0010) begin
        hits++;
        checks++; if (res_p !== 18'h1F7C1) begin errors++; $display("FAIL ext_max: got %h expected 1f7c1", res_p); end
      end else if (res_valid == 4'b0100) begin
        hits++;
        checks++; if (res_p !== 18'h00000) begin errors++; $display("FAIL ext_zero: got %h expected 00000", res_p); end
      end
      cycle();
    end
    checks++; if (hits != 3) begin errors++; $display("FAIL ext_count: got %0d results expected 3", hits); end
  endtask

  task automatic test_reset_midflight();
    tb_a[0] = 12'h0AB; tb_b[0] = 6'd11;
    tb_a[1] = 12'hF00; tb_b[1] = 6'd33;
    tb_a[2] = 12'h155; tb_b[2] = 6'd50;
    tb_a[3] = 12'h9C4; tb_b[3] = 6'd3;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'(1 << k);
      cycle();
    end
    req_valid = 4'b0000;
    #1;
    checks++; if (inflight !== 2'd3 || res_valid !== 4'b0001) begin errors++; $display("FAIL rst_pre: got inflight=%0d valid=%b expected 3/0001", inflight, res_valid); end
    #1;
    ap_rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL rst_res_valid: got %b expected 0000", res_valid); end
    checks++; if (inflight !== 2'd0)     begin errors++; $display("FAIL rst_inflight: got %0d expected 0", inflight); end
    sb.delete();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b expected 0001", req_ready); end
    cycle();
    req_valid = 4'b0000;
    repeat (5) cycle();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_drain: outstanding=%0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_extremes();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
